// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the pipelined RISC-V core's memory stage.
//   - result_src encodings for the writeback mux
//   - funct3 load/store width and sign constants
//   - memory-access FSM state enum and access-size enum
package riscv_pkg;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Load/store funct3 encodings (stores reuse the B/H/W codes)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational byte-lane handling for the memory stage.
// Ports:
//   access      in   an access (load or store) is present
//   is_store    in   1 = store, 0 = load
//   funct3      in   width/sign field
//   addr_lo     in   effective address bits [1:0]
//   store_data  in   unaligned store data (byte/half in the low bits)
//   load_word   in   raw word read from memory
//   wstrb       out  byte strobes
//   wdata       out  lane-replicated store data
//   load_data   out  lane-selected, extended load value
//   misaligned  out  access present with an illegal address for its width
module load_store_align
  import riscv_pkg::*;
(
  input  logic        access,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  access_size_e size;
  logic         load_signed;
  logic [7:0]   byte_lane;
  logic [15:0]  half_lane;

  // Decode width and sign; unknown funct3 codes fall back to a full word.
  always_comb begin
    size        = SZ_WORD;
    load_signed = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B:    size = SZ_BYTE;
        F3_H:    size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_B:    begin size = SZ_BYTE; load_signed = 1'b1; end
        F3_H:    begin size = SZ_HALF; load_signed = 1'b1; end
        F3_BU:   size = SZ_BYTE;
        F3_HU:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end
  end

  // Lane pick from the read word
  always_comb begin
    byte_lane = load_word[7:0];
    case (addr_lo)
      2'd0: byte_lane = load_word[7:0];
      2'd1: byte_lane = load_word[15:8];
      2'd2: byte_lane = load_word[23:16];
      2'd3: byte_lane = load_word[31:24];
      default: byte_lane = load_word[7:0];
    endcase
    half_lane = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  // Strobes, store replication and load extension per access size
  always_comb begin
    wstrb     = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{load_signed & byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{load_signed & half_lane[15]}}, half_lane};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata     = store_data;
        load_data = load_word;
      end
    endcase
  end

  assign misaligned = access &
                      (((size == SZ_HALF) & addr_lo[0]) |
                       ((size == SZ_WORD) & (addr_lo != 2'b00)));

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
// Ports:
//   clk, reset (async, active low)
//   EX/MEM inputs: reg_write_m, result_src_m, mem_write_m, funct3_m,
//                  alu_result_m, write_data_m, pc_plus_4_m, rd_m
//   stall_m           out  holds EX/MEM and everything upstream
//   req_valid/req_we/req_addr/req_wstrb/req_wdata out, req_ready in
//   resp_valid/resp_rdata in
//   reg_write_w/rd_w/result_w out  MEM/WB register
//   misalign_err      out  one-cycle pulse for a misaligned access
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_m,
  input  logic [1:0]        result_src_m,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [31:0]       alu_result_m,
  input  logic [31:0]       write_data_m,
  input  logic [31:0]       pc_plus_4_m,
  input  logic [4:0]        rd_m,
  output logic              stall_m,
  output logic              req_valid,
  output logic              req_we,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [3:0]        req_wstrb,
  output logic [31:0]       req_wdata,
  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata,
  output logic              reg_write_w,
  output logic [4:0]        rd_w,
  output logic [31:0]       result_w,
  output logic              misalign_err
);

  mem_state_e  state, state_next;
  logic        access;
  logic        misaligned;
  logic        aligned_access;
  logic        resp_done;
  logic [31:0] load_data;
  logic [31:0] wb_result;

  assign access         = mem_write_m | (result_src_m == RES_MEM);
  assign aligned_access = access & ~misaligned;

  load_store_align u_align (
    .access     (access),
    .is_store   (mem_write_m),
    .funct3     (funct3_m),
    .addr_lo    (alu_result_m[1:0]),
    .store_data (write_data_m),
    .load_word  (resp_rdata),
    .wstrb      (req_wstrb),
    .wdata      (req_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign req_addr = {alu_result_m[ADDR_W-1:2], 2'b00};
  assign req_we   = mem_write_m;

  // Responses only count in WAIT, so a stale response arriving in IDLE
  // (e.g. after a reset dropped the access) is ignored.
  assign resp_done = (state == MEM_WAIT) & resp_valid;

  // reset gates the combinational outputs so nothing leaks while held in reset
  assign stall_m = reset & aligned_access & ~resp_done;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MEM_IDLE;
    else        state <= state_next;
  end

  // Request issue and response wait
  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (reset & aligned_access) begin
          req_valid = 1'b1;
          if (req_ready) state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (resp_valid) state_next = MEM_IDLE;
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  // Writeback result select; encoding 11 behaves like ALU
  always_comb begin
    case (result_src_m)
      RES_MEM: wb_result = load_data;
      RES_PC4: wb_result = pc_plus_4_m;
      default: wb_result = alu_result_m;
    endcase
  end

  // MEM/WB register: stalls and misaligned accesses insert a bubble and
  // keep the previous rd/result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_w  <= 1'b0;
      rd_w         <= 5'd0;
      result_w     <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misaligned;
      if (stall_m || misaligned) begin
        reg_write_w <= 1'b0;
      end else begin
        reg_write_w <= reg_write_m;
        rd_w        <= rd_m;
        result_w    <= wb_result;
      end
    end
  end

endmodule
